tdp_ram_portb_arbiter: RTL
==========================

// Module: tdp_ram_portb_arbiter
// PURPOSE
//  Shares data port B of the dual-port instruction/data RAM between two OBI-style requesters:
//  M0 = core LSU (data bus), M1 = program loader / debug master.
//  Converts byte addresses to RAM word addresses, grants one request per cycle, and returns rvalid/rdata
//  one cycle after grant, matching the RAM's 1-cycle synchronous read.
//  Adds a loader burst lock and anti-starvation for M1. Port A (instruction fetch) is not touched.
// PARAMETERS
//  ADDR_WIDTH    14  RAM word-address width; ram_addr_o = mX_addr_i[ADDR_WIDTH+1:2]
//  DATA_WIDTH    32  data width; byte enables are DATA_WIDTH/8
//  STARVE_LIMIT  8   consecutive M1 wait cycles before M1 is forced; 0 disables the feature
// PORTS
//  clk_i         in   1           clock, all state on rising edge
//  rst_ni        in   1           asynchronous active-low reset
//  mX_req_i      in   1           X in {0,1}: request valid
//  mX_gnt_o      out  1           request accepted this cycle (combinational from req/state)
//  mX_addr_i     in   32          byte address; bits [1:0] and above ADDR_WIDTH+1 ignored (aliasing)
//  mX_we_i       in   1           1 = write
//  mX_be_i       in   DATA_WIDTH/8  byte enables (writes only)
//  mX_wdata_i    in   DATA_WIDTH  write data
//  mX_rvalid_o   out  1           response valid, exactly 1 cycle after mX_gnt_o (reads and writes)
//  mX_rdata_o    out  DATA_WIDTH  = ram_rdata_i; meaningful only with mX_rvalid_o
//  m1_lock_i     in   1           M1 burst lock: keep port ownership after this grant
//  ram_en_o      out  1           = m0_gnt_o | m1_gnt_o
//  ram_addr_o    out  ADDR_WIDTH  word address of the granted master
//  ram_we_o      out  1           granted we; 0 when idle
//  ram_be_o      out  DATA_WIDTH/8  granted be when writing, else 0
//  ram_wdata_o   out  DATA_WIDTH  granted wdata
//  ram_rdata_i   in   DATA_WIDTH  RAM port-B read data (valid the cycle after ram_en_o)
// BEHAVIOUR
//  Reset: state=ARB, rvalid_q=2'b00, starve_cnt=0, last_owner=M1; all outputs 0 while rst_ni=0.
//  Reset mid-transaction drops the pending rvalid; no response is issued.
//  At most one gnt per cycle; gnt never asserted without req; ram_* muxed from the granted master.
//  Idle cycles: ram_en_o=0, ram_we_o=0, ram_be_o=0.
//  rvalid_q[X] <= mX_gnt_o; back-to-back grants give back-to-back rvalids, no bubbles.
//  FSM states:
//   ARB: fixed priority M0 > M1, except M1 wins when starve_cnt == STARVE_LIMIT (STARVE_LIMIT != 0).
//        M1 granted with m1_lock_i=1 -> go to M1_LOCK.
//   M1_LOCK: only M1 may be granted; M0 gnt=0.
//        A granted M1 beat with m1_lock_i=0 -> ARB.
//        m1_req_i=0 and m1_lock_i=0 in the same cycle -> ARB.
//        m1_lock_i held with m1_req_i=0 -> stay in M1_LOCK (port idle).
//  starve_cnt: +1 each cycle m1_req_i && !m1_gnt_o, saturating at STARVE_LIMIT; cleared on m1_gnt_o or !m1_req_i.
//  Simultaneous req, no starvation, ARB: M0 granted; M1 rvalid can never collide with an M0 rvalid.
//  Address wrap: byte addr 4*2**ADDR_WIDTH aliases word 0.
// CONFIGURATION
//  TDP_ARB_ROUND_ROBIN_EN defined: in ARB, when both request, grant the master != last_owner.
//    last_owner updates on every grant. starve_cnt is still implemented but can never reach its limit.
//  Not defined: fixed priority plus starvation counter, as above. Lock behaviour is identical in both.
// STRUCTURE
//  Package tdp_arb_pkg: typedef enum logic {ARB, M1_LOCK} arb_state_e; localparam M0_IDX=0, M1_IDX=1;
//  typedef for the request struct {addr, we, be, wdata}.
//  Single module, no sub-modules; grant logic is an always_comb; state, rvalid_q, starve_cnt and
//  last_owner sit in one always_ff with async reset.
// TESTING (bench: this block + RAM, ADDR_WIDTH=14)
//  1. M0 write 0x0000_0010 data 0xDEADBEEF be 4'hF, then read -> ram_addr_o=4;
//     m0_rvalid_o 1 cycle after each gnt; rdata 0xDEADBEEF.
//  2. Both req every cycle, STARVE_LIMIT=8, fixed priority -> M0 gets 8 grants, M1 granted on the 9th cycle.
//     Repeat with the macro defined -> grants alternate M0, M1, M0...
//  3. M1 req with lock=1 for 4 beats (addr 0x100..0x10C) while M0 requests.
//     -> m0_gnt_o=0 throughout; m0 granted the cycle after the M1 beat with lock=0.
//  4. M1 write be=4'b0110 data 0x11223344 over 0xFFFFFFFF, then read back -> 0xFF2233FF.
//  5. Assert rst_ni=0 the cycle after an M0 read grant -> m0_rvalid_o stays 0.
//     After release: state ARB, starve_cnt=0.
//  6. M0 read of byte addr 0x0001_0000 -> ram_addr_o=0 (wrap); data equals word 0.

Source files
------------

// File: rtl/tdp_arb_pkg.sv
// Shared types and helpers for the port-B arbiter of the instruction/data RAM.
// The round-robin variant is selected in the arbiter by defining TDP_ARB_ROUND_ROBIN_EN.
package tdp_arb_pkg;

  typedef enum logic {ARB = 1'b0, M1_LOCK = 1'b1} arb_state_e;

  localparam int unsigned M0_IDX = 0;
  localparam int unsigned M1_IDX = 1;

  // Struct fields are sized for the widest supported RAM; the arbiter uses the low bits.
  localparam int unsigned MAX_DATA_WIDTH = 64;
  localparam int unsigned MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  typedef struct packed {
    logic [31:0]               addr;
    logic                      we;
    logic [MAX_BE_WIDTH-1:0]   be;
    logic [MAX_DATA_WIDTH-1:0] wdata;
  } arb_req_t;

  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/tdp_ram_portb_arbiter.sv
// Two-master arbiter for RAM port B (M0 = LSU, M1 = loader/debug) with M1 burst lock.
// Define TDP_ARB_ROUND_ROBIN_EN for round-robin in ARB; default is fixed priority + anti-starvation.
module tdp_ram_portb_arbiter
  import tdp_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  input  logic [31:0]             m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  input  logic [31:0]             m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  input  logic                    m1_lock_i,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned CntWidth = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntWidth-1:0] StarveMax = CntWidth'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [1:0]          rvalid_q;
  logic [CntWidth-1:0] starve_cnt_q, starve_cnt_d;
  logic                last_owner_q, last_owner_d;

  arb_req_t    m0_req_s, m1_req_s, sel_req;
  logic [31:0] word_addr;
  logic        unused_sel;

  always_comb begin
    m0_req_s                     = '0;
    m0_req_s.addr                = m0_addr_i;
    m0_req_s.we                  = m0_we_i;
    m0_req_s.be[BeWidth-1:0]     = m0_be_i;
    m0_req_s.wdata[DATA_WIDTH-1:0] = m0_wdata_i;
    m1_req_s                     = '0;
    m1_req_s.addr                = m1_addr_i;
    m1_req_s.we                  = m1_we_i;
    m1_req_s.be[BeWidth-1:0]     = m1_be_i;
    m1_req_s.wdata[DATA_WIDTH-1:0] = m1_wdata_i;
  end

`ifndef TDP_ARB_ROUND_ROBIN_EN
  logic starve_hit;
  assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt_q == StarveMax);
`endif

  // Grants are forced low during reset so every output reads 0 while rst_ni is asserted.
  always_comb begin
    m0_gnt_o = 1'b0;
    m1_gnt_o = 1'b0;
    state_d  = state_q;
    if (rst_ni) begin
      unique case (state_q)
        ARB: begin
`ifdef TDP_ARB_ROUND_ROBIN_EN
          if (m0_req_i && m1_req_i) begin
            if (last_owner_q == 1'(M1_IDX)) m0_gnt_o = 1'b1;
            else                            m1_gnt_o = 1'b1;
          end else begin
            m0_gnt_o = m0_req_i;
            m1_gnt_o = m1_req_i;
          end
`else
          if (m1_req_i && starve_hit) m1_gnt_o = 1'b1;
          else if (m0_req_i)          m0_gnt_o = 1'b1;
          else                        m1_gnt_o = m1_req_i;
`endif
          if (m1_gnt_o && m1_lock_i) state_d = M1_LOCK;
        end
        M1_LOCK: begin
          m1_gnt_o = m1_req_i;
          // Dropping the lock releases the port whether or not M1 issues a final beat.
          if (!m1_lock_i) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req_i || m1_gnt_o)        starve_cnt_d = '0;
    else if (starve_cnt_q != StarveMax) starve_cnt_d = starve_cnt_q + 1'b1;
    last_owner_d = last_owner_q;
    if (m0_gnt_o)      last_owner_d = 1'(M0_IDX);
    else if (m1_gnt_o) last_owner_d = 1'(M1_IDX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB;
      rvalid_q     <= 2'b00;
      starve_cnt_q <= '0;
      last_owner_q <= 1'(M1_IDX);
    end else begin
      state_q      <= state_d;
      rvalid_q     <= {m1_gnt_o, m0_gnt_o};
      starve_cnt_q <= starve_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign sel_req   = m1_gnt_o ? m1_req_s : m0_req_s;
  assign word_addr = byte_to_word(sel_req.addr);

  assign ram_en_o    = m0_gnt_o | m1_gnt_o;
  assign ram_addr_o  = ram_en_o ? word_addr[ADDR_WIDTH-1:0] : '0;
  assign ram_we_o    = ram_en_o & sel_req.we;
  assign ram_be_o    = (ram_en_o && sel_req.we) ? sel_req.be[BeWidth-1:0] : '0;
  assign ram_wdata_o = ram_en_o ? sel_req.wdata[DATA_WIDTH-1:0] : '0;

  assign m0_rvalid_o = rvalid_q[M0_IDX];
  assign m1_rvalid_o = rvalid_q[M1_IDX];
  assign m0_rdata_o  = rst_ni ? ram_rdata_i : '0;
  assign m1_rdata_o  = rst_ni ? ram_rdata_i : '0;

  // Aliased address bits and spare struct width are intentionally dropped.
  assign unused_sel = ^{sel_req, word_addr};

endmodule
